multi2: RTL and testbench

Unsigned 2-bit × 2-bit multiplier with a registered 4-bit product. It is the multiply primitive of the calculator datapath: operands come from the operand registers, and the product feeds the result/display path. The arithmetic is a structural AND-array / half-adder network, followed by one output register stage and a valid flag.

---
 rtl/multi2.sv | 48 ++++
 tb/tb_multi2.sv | 118 +++++++++++
 2 files changed

// File: rtl/multi2.sv
// rtl/multi2.sv - registered 2x2 unsigned multiplier built from an AND array and half adders

module half_adder (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);
  assign sum   = x ^ y;
  assign carry = x & y;
endmodule

module multi2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       in_valid,
  output logic [3:0] s,
  output logic       out_valid
);
  logic p00, p01, p10, p11;
  logic d1, c1, d2, c2;
  logic [3:0] prod;

  assign p00 = a[0] & b[0];
  assign p01 = a[1] & b[0];
  assign p10 = a[0] & b[1];
  assign p11 = a[1] & b[1];

  half_adder u_ha1 (.x(p01), .y(p10), .sum(d1), .carry(c1));
  half_adder u_ha2 (.x(p11), .y(c1),  .sum(d2), .carry(c2));

  assign prod = {c2, d2, d1, p00};

  // s holds its last product when in_valid is low; only the flag drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s <= prod;
      end
    end
  end
endmodule

// File: tb/tb_multi2.sv
// tb/tb_multi2.sv - directed self-checking bench for multi2

module tb_multi2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] a = 2'd3;
  logic [1:0] b = 2'd3;
  logic       in_valid = 1'b1;
  logic [3:0] s;
  logic       out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // expected products indexed by {b, a}
  logic [3:0] exp_tab [16] = '{4'd0, 4'd0, 4'd0, 4'd0,
                               4'd0, 4'd1, 4'd2, 4'd3,
                               4'd0, 4'd2, 4'd4, 4'd6,
                               4'd0, 4'd3, 4'd6, 4'd9};

  multi2 dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .in_valid(in_valid),
    .s(s),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // drive operands, take one rising edge, settle just past it
  task automatic apply(input logic [1:0] av, input logic [1:0] bv, input logic vv);
    a = av;
    b = bv;
    in_valid = vv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("reset_s_imm", s, 4'b0000);
    check("reset_ov_imm", {3'b0, out_valid}, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_s_held", s, 4'b0000);
    check("reset_ov_held", {3'b0, out_valid}, 4'b0000);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_s", s, 4'b1001);
    check("post_reset_ov", {3'b0, out_valid}, 4'b0001);

    for (int bi = 0; bi < 4; bi++) begin
      for (int ai = 0; ai < 4; ai++) begin
        apply(ai[1:0], bi[1:0], 1'b1);
        check($sformatf("sweep_%0dx%0d", ai, bi), s, exp_tab[bi*4 + ai]);
        check($sformatf("sweep_ov_%0dx%0d", ai, bi), {3'b0, out_valid}, 4'b0001);
      end
    end

    apply(2'd3, 2'd3, 1'b1);
    check("carry_3x3", s, 4'b1001);
    apply(2'd2, 2'd3, 1'b1);
    check("carry_2x3", s, 4'b0110);

    apply(2'd3, 2'd2, 1'b1);
    check("hold_capture", s, 4'b0110);
    apply(2'd1, 2'd1, 1'b0);
    check("hold_s", s, 4'b0110);
    check("hold_ov", {3'b0, out_valid}, 4'b0000);
    apply(2'd1, 2'd1, 1'b0);
    check("hold_s_again", s, 4'b0110);

    apply(2'd1, 2'd3, 1'b1);
    check("b2b_1x3", s, 4'b0011);
    check("b2b_ov0", {3'b0, out_valid}, 4'b0001);
    apply(2'd3, 2'd1, 1'b1);
    check("b2b_3x1", s, 4'b0011);
    check("b2b_ov1", {3'b0, out_valid}, 4'b0001);
    apply(2'd2, 2'd2, 1'b1);
    check("b2b_2x2", s, 4'b0100);
    check("b2b_ov2", {3'b0, out_valid}, 4'b0001);

    apply(2'd3, 2'd3, 1'b1);
    apply(2'd3, 2'd3, 1'b1);
    check("recapture_s", s, 4'b1001);
    check("recapture_ov", {3'b0, out_valid}, 4'b0001);

    #1;
    rst = 1'b1;
    #1;
    check("async_rst_s", s, 4'b0000);
    check("async_rst_ov", {3'b0, out_valid}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    apply(2'd2, 2'd3, 1'b1);
    check("resume_2x3", s, 4'b0110);
    check("resume_ov", {3'b0, out_valid}, 4'b0001);
    apply(2'd3, 2'd1, 1'b1);
    check("resume_3x1", s, 4'b0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
